// File: rtl/tower_bit_deser_if.sv
// Bus-side bundle for tower_bit_deser: serial bit input, FIFO head word, status and clear.
// drop_cnt is present only when TOWER_BIT_DESER_DROP_CNT_EN is defined.
interface tower_bit_deser_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             bit_in;
  logic             bit_en;
  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic             word_ready;
  logic [LW-1:0]    fifo_level;
  logic             overflow;
  logic             ovf_clr;
`ifdef TOWER_BIT_DESER_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  modport slave (
    input  bit_in, bit_en, word_ready, ovf_clr,
    output word_data, word_valid, fifo_level, overflow
`ifdef TOWER_BIT_DESER_DROP_CNT_EN
    , output drop_cnt
`endif
  );

  modport master (
    output bit_in, bit_en, word_ready, ovf_clr,
    input  word_data, word_valid, fifo_level, overflow
`ifdef TOWER_BIT_DESER_DROP_CNT_EN
    , input drop_cnt
`endif
  );
endinterface

// File: rtl/tower_bit_deser.sv
// MSB-first serial-to-word deserializer feeding a first-word-fall-through FIFO with sticky overflow.
// Optional saturating dropped-word counter enabled by TOWER_BIT_DESER_DROP_CNT_EN.
module tower_bit_deser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  tower_bit_deser_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;

  logic [WIDTH-1:0] r_shr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_overflow;

  logic [WIDTH-1:0] w_word;
  logic [PW-1:0]    w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;

  assign w_word    = {r_shr[WIDTH-2:0], bus.bit_in};
  assign w_push    = bus.bit_en && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_level == PW'(DEPTH));
  assign w_empty   = (w_level == '0);
  assign w_pop     = !w_empty && bus.word_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still take the word.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shr <= '0;
      r_cnt <= '0;
    end else if (bus.bit_en) begin
      r_shr <= w_word;
      r_cnt <= w_push ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_word;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
    else if (bus.ovf_clr)  r_overflow <= 1'b0;
  end

`ifdef TOWER_BIT_DESER_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                r_drop_cnt <= '0;
    else if (bus.ovf_clr)                   r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign bus.drop_cnt = r_drop_cnt;
`endif

  assign bus.word_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.word_valid = !w_empty;
  assign bus.fifo_level = w_level;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_tower_bit_deser.sv
// Directed bench for tower_bit_deser: expected words queued on push, compared on each pop.
module tb_tower_bit_deser;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  tower_bit_deser_if #(.WIDTH(8), .DEPTH(4)) bus ();

  tower_bit_deser #(.WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; a handshake seen just before the edge is scored against the queue head.
  task automatic step();
    logic [7:0] e;
    if (bus.word_valid === 1'b1 && bus.word_ready === 1'b1 && !rst) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(bus.word_data), 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", 32'(bus.word_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_en = 1'b1;
    bus.bit_in = b;
    step();
    bus.bit_en = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(w[i]);
  endtask

  task automatic drain(input int n);
    bus.word_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    bus.word_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1;
    bus.bit_in = 1'b0;
    bus.bit_en = 1'b0;
    bus.word_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.word_valid), 0);
    chk("rst_level", 32'(bus.fifo_level), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_data", 32'(bus.word_data), 0);
`ifdef TOWER_BIT_DESER_DROP_CNT_EN
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 0);
`endif

    // Single word 1,0,1,1,0,0,1,0 = B2
    send_bits(8'hB2, 7);
    chk("single_no_early_valid", 32'(bus.word_valid), 0);
    send_bits(8'h20, 1);
    exp_q.push_back(8'hB2);
    chk("single_valid", 32'(bus.word_valid), 1);
    chk("single_data", 32'(bus.word_data), 32'hB2);
    chk("single_level", 32'(bus.fifo_level), 1);
    drain(1);
    chk("single_valid_after_pop", 32'(bus.word_valid), 0);
    chk("single_level_after_pop", 32'(bus.fifo_level), 0);

    // Gapped input
    send_bits(8'hB2, 4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_no_valid", 32'(bus.word_valid), 0);
    end
    w = 8'hB2 << 4;
    send_bits(w, 4);
    exp_q.push_back(8'hB2);
    chk("gap_valid", 32'(bus.word_valid), 1);
    chk("gap_data", 32'(bus.word_data), 32'hB2);
    drain(1);

    // Fill and overflow
    for (int k = 1; k <= 4; k++) begin
      send_bits(8'(k), 8);
      exp_q.push_back(8'(k));
    end
    chk("fill_level4", 32'(bus.fifo_level), 4);
    chk("fill_ovf0", 32'(bus.overflow), 0);
    send_bits(8'h05, 8);
    chk("ovf_level4", 32'(bus.fifo_level), 4);
    chk("ovf_set", 32'(bus.overflow), 1);
`ifdef TOWER_BIT_DESER_DROP_CNT_EN
    chk("ovf_drop_cnt1", 32'(bus.drop_cnt), 1);
`endif
    drain(4);
    chk("ovf_drained_level", 32'(bus.fifo_level), 0);
    chk("ovf_sticky", 32'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 0);
`ifdef TOWER_BIT_DESER_DROP_CNT_EN
    chk("drop_cnt_cleared", 32'(bus.drop_cnt), 0);
`endif

    // Full with simultaneous pop: 5th word lands in the pop cycle
    for (int k = 1; k <= 4; k++) begin
      send_bits(8'(k), 8);
      exp_q.push_back(8'(k));
    end
    send_bits(8'h05, 7);
    chk("fullpop_level_before", 32'(bus.fifo_level), 4);
    bus.word_ready = 1'b1;
    send_bit(1'b1);
    exp_q.push_back(8'h05);
    chk("fullpop_level", 32'(bus.fifo_level), 4);
    chk("fullpop_no_ovf", 32'(bus.overflow), 0);
    drain(4);
    chk("fullpop_empty", 32'(bus.fifo_level), 0);

    // Clear priority: drop and ovf_clr in the same cycle
    for (int k = 10; k <= 13; k++) begin
      send_bits(8'(k), 8);
      exp_q.push_back(8'(k));
    end
    send_bits(8'h0E, 8);
    chk("prio_ovf_set", 32'(bus.overflow), 1);
    send_bits(8'h0F, 7);
    bus.ovf_clr = 1'b1;
    send_bit(1'b1);
    chk("prio_set_wins", 32'(bus.overflow), 1);
`ifdef TOWER_BIT_DESER_DROP_CNT_EN
    chk("prio_drop_cnt1", 32'(bus.drop_cnt), 1);
`endif
    step();
    bus.ovf_clr = 1'b0;
    chk("prio_clr_alone", 32'(bus.overflow), 0);
`ifdef TOWER_BIT_DESER_DROP_CNT_EN
    chk("prio_drop_cnt0", 32'(bus.drop_cnt), 0);
`endif
    drain(4);

    // Reset mid-word, with a stale word in the FIFO that reset must discard
    send_bits(8'h55, 8);
    chk("pre_rst_level", 32'(bus.fifo_level), 1);
    send_bits(8'hFF, 5);
    rst = 1'b1;
    bus.bit_en = 1'b1;
    bus.bit_in = 1'b1;
    step();
    chk("rst_mid_level", 32'(bus.fifo_level), 0);
    chk("rst_mid_valid", 32'(bus.word_valid), 0);
    rst = 1'b0;
    bus.bit_en = 1'b0;
    send_bits(8'h3C, 8);
    exp_q.push_back(8'h3C);
    chk("rst_mid_data", 32'(bus.word_data), 32'h3C);
    chk("rst_mid_level1", 32'(bus.fifo_level), 1);
    drain(1);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tower_bit_deser.md
Name: tower_bit_deser

Overview:
- Downstream consumer of the state-tower top level's 1-bit output stream.
- Accumulates serial bits MSB-first into WIDTH-bit words and buffers them in a DEPTH-entry FIFO.
- Presents the words on a valid/ready interface to the bus-side logic.
- Sticky overflow flag records any word lost to a full FIFO.

Parameters:
- WIDTH, 8: bits per word; legal values >= 2.
- DEPTH, 4: FIFO entries; power of 2, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- bit_in  input  1  serial data bit, driven from the tower output.
- bit_en  input  1  bit_in sampled this cycle when 1.
- word_data  output  WIDTH  head-of-FIFO word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts the head word when valid && ready.
- fifo_level  output  $clog2(DEPTH)+1  entries currently held.
- overflow  output  1  sticky; set when a completed word is dropped.
- ovf_clr  input  1  clears overflow.
- drop_cnt  output  8  dropped-word count; present only with the optional feature.

Behaviour:
- Reset (rst=1 at an edge):
  - shift register, bit counter, FIFO pointers, overflow and drop_cnt go to 0.
  - Outputs: word_valid=0, fifo_level=0, overflow=0, word_data=0.
  - A partially assembled word is discarded; reset overrides all other inputs in that cycle.
- Deserializer:
  - Holds shr[WIDTH-1:0] and cnt (0..WIDTH-1).
  - When bit_en=1: shr <= {shr[WIDTH-2:0], bit_in} and cnt <= cnt+1.
  - When bit_en=1 and cnt==WIDTH-1: completed word = {shr[WIDTH-2:0], bit_in}; cnt wraps to 0 and push is requested this cycle.
  - When bit_en=0: shr and cnt hold.
  - The first bit received is the word MSB.
- FIFO:
  - Circular buffer with rd/wr pointers of $clog2(DEPTH)+1 bits.
  - full = (level==DEPTH); empty = (level==0).
  - word_data is a combinational read of the head entry, i.e. first-word-fall-through. When empty, word_data shows the stale entry; it is not valid.
  - pop = word_valid && word_ready.
  - push_ok = push && (!full || pop). When full, a simultaneous pop frees the slot and the push is accepted.
  - Level update: level' = level + push_ok - pop.
  - Latency: the WIDTH-th bit at edge N gives word_valid=1 with that word after edge N, provided the FIFO was empty.
  - Push and pop in the same cycle with level unchanged is legal at every level, including DEPTH.
  - word_ready while word_valid=0 is ignored.
  - Pointer wrap-around is natural modulo 2*DEPTH; level is derived from the pointer difference.
- Overflow:
  - push && full && !pop drops the word: no FIFO change, overflow <= 1.
  - The deserializer continues with the next word (cnt is already 0).
  - ovf_clr=1 clears overflow at the next edge.
  - If a drop and ovf_clr occur in the same cycle, set wins (overflow=1).
- Mid-word bit_en gaps of any length are tolerated; no timeout.

Optional Feature:
- Macro: TOWER_BIT_DESER_DROP_CNT_EN.
- Defined:
  - drop_cnt port exists.
  - Increments by 1 on each dropped word and saturates at 8'hFF.
  - ovf_clr also clears it to 0; with a simultaneous drop it becomes 1.
- Undefined:
  - drop_cnt port and counter are absent.
  - All other behaviour is identical.

Test Plan (WIDTH=8, DEPTH=4):
- Single word: after reset, feed bits 1,0,1,1,0,0,1,0 on 8 consecutive bit_en cycles, word_ready=0.
  - word_valid=1 the cycle after the 8th bit; word_data=8'hB2; fifo_level=1.
  - Assert ready: valid=0 next cycle, level=0.
- Gapped input: same 8 bits with bit_en=0 for 3 cycles between bits 4 and 5 → word_data=8'hB2; no early valid.
- Fill and overflow: push 5 words 8'h01..8'h05 with ready=0.
  - After the 4th word: level=4, overflow=0.
  - After the 5th word: level=4, overflow=1, drop_cnt=1 (feature on).
  - Drain: read sequence 01,02,03,04.
- Full with simultaneous pop: level=4, ready=1 held, 5th word completes in the pop cycle.
  - No drop; level stays 4; overflow=0.
  - Full drain order: 01..05.
- Clear priority: overflow=1, assert ovf_clr in the same cycle as another drop → overflow stays 1. ovf_clr alone next cycle → overflow=0.
- Reset mid-word: after 5 bits assert rst for 1 cycle, then feed 8 bits of 8'h3C.
  - Output is 8'h3C; fifo_level=0 during rst; no residue from the partial word.
